// File: rtl/gpi_pkg.sv
// gpi_pkg: shared definitions for the GPI slot.
//   reg_addr_t      5-bit register index on the slot bus
//   REG_*           register map of the slot
//   cnt_width()     width of a debounce counter able to hold 0..DB_CYCLES
package gpi_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_DATA    = 5'd0;
  localparam reg_addr_t REG_CAP     = 5'd1;
  localparam reg_addr_t REG_RISE_EN = 5'd2;
  localparam reg_addr_t REG_FALL_EN = 5'd3;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gpi_if.sv
// gpi_if: standard slot bus.
//   cs, read, write  chip select and strobes (driven by the master)
//   addr             register index
//   wr_data          write data
//   rd_data          combinational read data (driven by the slave)
interface gpi_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/gpi_debounce.sv
// gpi_debounce: one-bit debouncer for a synchronized input.
//   clk_i     system clock
//   reset_ni  synchronous active-low reset
//   s2_i      synchronized input bit
//   db_o      debounced bit (registered)
//   db_nxt_o  value db_o takes at the next clock, used for edge detection
// db only follows s2 after DB_CYCLES consecutive cycles of disagreement.
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic s2_i,
  output logic db_o,
  output logic db_nxt_o
);

  localparam int unsigned   CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_i != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = s2_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o     = db_q;
  assign db_nxt_o = db_d;

endmodule

// File: rtl/gpi_core.sv
// gpi_core: general-purpose input slot core.
//   clk_i     system clock
//   reset_ni  synchronous active-low reset
//   bus       slot bus (slave side): DATA/CAP/RISE_EN/FALL_EN registers
//   din_i     asynchronous external pins
//   irq_o     level interrupt, high while any capture bit is set
// Build option: define GPI_DEBOUNCE_EN to insert the per-bit debouncer;
// otherwise db simply registers the synchronizer output.
module gpi_core
  import gpi_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  gpi_if.slave         bus,
  input  logic [W-1:0] din_i,
  output logic         irq_o
);

  logic [W-1:0] s1_q, s2_q;
  logic [W-1:0] db, db_nxt;
  logic [W-1:0] cap_q, cap_d;
  logic [W-1:0] rise_en_q, rise_en_d;
  logic [W-1:0] fall_en_q, fall_en_d;
  logic [W-1:0] clr, rise, fall;
  logic [31:0]  rd;
  logic         wr_en;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

`ifdef GPI_DEBOUNCE_EN
  for (genvar i = 0; i < int'(W); i++) begin : g_db
    gpi_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .s2_i     (s2_q[i]),
      .db_o     (db[i]),
      .db_nxt_o (db_nxt[i])
    );
  end
`else
  localparam int unsigned db_cycles_unused = DB_CYCLES;
  logic [W-1:0] db_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      db_q <= '0;
    end else begin
      db_q <= s2_q;
    end
  end

  assign db     = db_q;
  assign db_nxt = s2_q;
`endif

  assign wr_en = bus.cs && bus.write;

  always_comb begin
    clr       = '0;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_en) begin
      case (bus.addr)
        REG_CAP:     clr       = bus.wr_data[W-1:0];
        REG_RISE_EN: rise_en_d = bus.wr_data[W-1:0];
        REG_FALL_EN: fall_en_d = bus.wr_data[W-1:0];
        default:     ;
      endcase
    end
    // Edges are taken on the cycle db changes, so cap and db update together.
    rise  = ~db & db_nxt;
    fall  = db & ~db_nxt;
    // A new edge overrides a same-cycle write-1-to-clear.
    cap_d = (cap_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cap_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      cap_q     <= cap_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.addr)
      REG_DATA:    rd[W-1:0] = db;
      REG_CAP:     rd[W-1:0] = cap_q;
      REG_RISE_EN: rd[W-1:0] = rise_en_q;
      REG_FALL_EN: rd[W-1:0] = fall_en_q;
      default:     ;
    endcase
  end

  assign bus.rd_data = rd;
  assign irq_o       = |cap_q;

  // Reads have no side effects and upper write bits are ignored.
  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.wr_data};

endmodule

// File: tb/tb_gpi_core.sv
module tb_gpi_core;
  localparam int W  = 8;
  localparam int DB = 4;
`ifdef GPI_DEBOUNCE_EN
  localparam int L = 2 + DB;
`else
  localparam int L = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       irq;

  gpi_if bus ();

  gpi_core #(.W(W), .DB_CYCLES(DB)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus),
    .din_i    (din),
    .irq_o    (irq)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pins delayed two clocks, db follows once the last DB
  // synchronized samples all disagree with it.
  logic [7:0] m_s1 = 0, m_s2 = 0, m_db = 0, m_cap = 0, m_rise = 0, m_fall = 0;
  logic [7:0] win[$];

  task automatic model_edge();
    logic [7:0] nxt, re, fe, clr;
    bit all_diff;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_cap = 0; m_rise = 0; m_fall = 0;
      win.delete();
    end else begin
`ifdef GPI_DEBOUNCE_EN
      win.push_back(m_s2);
      if (win.size() > DB) void'(win.pop_front());
      nxt = m_db;
      if (win.size() == DB) begin
        for (int b = 0; b < 8; b++) begin
          all_diff = 1'b1;
          foreach (win[i]) if (win[i][b] == m_db[b]) all_diff = 1'b0;
          if (all_diff) nxt[b] = ~m_db[b];
        end
      end
`else
      nxt = m_s2;
`endif
      re  = ~m_db & nxt;
      fe  = m_db & ~nxt;
      clr = (bus.cs && bus.write && bus.addr == 5'd1) ? bus.wr_data[7:0] : 8'h00;
      m_cap = (m_cap & ~clr) | (re & m_rise) | (fe & m_fall);
      if (bus.cs && bus.write && bus.addr == 5'd2) m_rise = bus.wr_data[7:0];
      if (bus.cs && bus.write && bus.addr == 5'd3) m_fall = bus.wr_data[7:0];
      m_db = nxt;
      m_s2 = m_s1;
      m_s1 = din;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    case (a)
      5'd0:    return {24'h0, m_db};
      5'd1:    return {24'h0, m_cap};
      5'd2:    return {24'h0, m_rise};
      5'd3:    return {24'h0, m_fall};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    chk(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    tick();
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = 5'd0; bus.wr_data = 32'h0;

    // 1: reset with pins high, then release
    rst_n = 1'b0; din = 8'hFF;
    tick(); tick();
    rd_chk("rst_data", 5'd0, 32'h0);
    rd_chk("rst_cap", 5'd1, 32'h0);
    rd_chk("rst_rise_en", 5'd2, 32'h0);
    rd_chk("rst_fall_en", 5'd3, 32'h0);
    irq_chk("rst_irq", 1'b0);
    rst_n = 1'b1;
    repeat (L - 1) tick();
    rd_chk("rel_data_early", 5'd0, 32'h0);
    tick();
    rd_chk("rel_data", 5'd0, 32'hFF);

    // 2: step latency
    din = 8'h00;
    repeat (L + 2) tick();
    rd_chk("step_base", 5'd0, 32'h00);
    din = 8'h01;
    repeat (L - 1) tick();
    rd_chk("step_early", 5'd0, 32'h00);
    tick();
    rd_chk("step_data", 5'd0, 32'h01);

    // 3: short pulse on bit 0 with rise enabled
    din = 8'h00;
    repeat (L + 2) tick();
    wr(5'd2, 32'h01);
    din = 8'h01;
    repeat (3) tick();
    din = 8'h00;
    repeat (L + 3) tick();
    rd_chk("pulse_data", 5'd0, 32'h00);
`ifdef GPI_DEBOUNCE_EN
    rd_chk("pulse_cap", 5'd1, 32'h00);
    irq_chk("pulse_irq", 1'b0);
`else
    rd_chk("pulse_cap", 5'd1, 32'h01);
    irq_chk("pulse_irq", 1'b1);
`endif
    wr(5'd1, 32'hFF);
    rd_chk("pulse_clr", 5'd1, 32'h00);

    // 4: rise capture and write-1-to-clear
    din = 8'h01;
    repeat (L - 1) tick();
    rd_chk("rise_cap_early", 5'd1, 32'h00);
    irq_chk("rise_irq_early", 1'b0);
    tick();
    rd_chk("rise_cap", 5'd1, 32'h01);
    irq_chk("rise_irq", 1'b1);
    rd_chk("rise_data", 5'd0, 32'h01);
    wr(5'd1, 32'h01);
    rd_chk("clr_cap", 5'd1, 32'h00);
    irq_chk("clr_irq", 1'b0);

    // 5: clear collides with a new edge on the same bit
    wr(5'd3, 32'h01);
    din = 8'h00;
    repeat (L) tick();
    rd_chk("fall_cap", 5'd1, 32'h01);
    din = 8'h01;
    repeat (L - 1) tick();
    rd_chk("pre_collide_cap", 5'd1, 32'h01);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd1; bus.wr_data = 32'h01;
    tick();
    bus.cs = 1'b0; bus.write = 1'b0;
    rd_chk("collide_cap", 5'd1, 32'h01);
    irq_chk("collide_irq", 1'b1);
    rd_chk("collide_data", 5'd0, 32'h01);
    wr(5'd1, 32'h01);
    rd_chk("collide_clr", 5'd1, 32'h00);

    // 6: ignored writes, unmapped reads, fall capture on bit 7
    wr(5'd0, 32'hAA);
    wr(5'd7, 32'hFF);
    rd_chk("ro_data", 5'd0, 32'h01);
    rd_chk("unmapped7", 5'd7, 32'h00);
    rd_chk("unmapped31", 5'd31, 32'h00);
    rd_chk("keep_rise_en", 5'd2, 32'h01);
    rd_chk("keep_fall_en", 5'd3, 32'h01);
    wr(5'd3, 32'h80);
    din = 8'h81;
    repeat (L + 2) tick();
    rd_chk("b7_rise_nocap", 5'd1, 32'h00);
    din = 8'h01;
    repeat (L - 1) tick();
    rd_chk("b7_fall_early", 5'd1, 32'h00);
    tick();
    rd_chk("b7_fall_cap", 5'd1, 32'h80);
    irq_chk("b7_fall_irq", 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) din = din ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) din = 8'($urandom);
      bus.read = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        bus.cs = 1'b1; bus.write = 1'b1;
        bus.addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        bus.wr_data = $urandom;
      end else begin
        bus.cs = 1'($urandom_range(0, 1));
        bus.write = ~bus.cs & 1'($urandom_range(0, 1));
        bus.addr = 5'($urandom);
        bus.wr_data = $urandom;
      end
      #1;
      chk("rand_rd", bus.rd_data, model_rd(bus.addr));
      irq_chk("rand_irq", |m_cap);
      tick();
    end
    bus.cs = 1'b0; bus.write = 1'b0; rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
